// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: load-use bubbles, branch flushes,
// mult/div stall sequencing and saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rt,
    input  logic             id_md_use,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt_addr,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] MD_RELOAD = 8'(MD_LATENCY - 1);

    state_t     state;
    state_t     next_state;
    logic [7:0] md_cnt;
    logic [7:0] md_cnt_next;
    logic       lu;
    logic       md_st;

    assign lu = id_valid & ex_mem_read & (ex_rt_addr != 5'd0) &
                ((ex_rt_addr == id_rs_addr) | (id_uses_rt & (ex_rt_addr == id_rt_addr)));
    assign md_st = (state == MD_WAIT) & id_valid & id_md_use;

    // A new mult/div start always reloads the counter, even mid-wait; branches never abort it.
    always_comb begin
        next_state  = state;
        md_cnt_next = md_cnt;
        if (ex_md_start) begin
            next_state  = MD_WAIT;
            md_cnt_next = MD_RELOAD;
        end else if (state == MD_WAIT) begin
            if (md_cnt != 8'd0) begin
                md_cnt_next = md_cnt - 8'd1;
            end else begin
                next_state = RUN;
            end
        end
    end

    // Priority: reset, then taken branch (stalled instruction is wrong-path), then stall.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        md_busy    = (state == MD_WAIT);
        if (rst) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            md_busy    = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (md_st | lu) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            md_cnt <= 8'd0;
        end else begin
            state  <= next_state;
            md_cnt <= md_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_write && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (ex_branch_taken && (flush_events != '1)) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end

endmodule
